uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 175 +++++++++++++++++
 tb/tb_uart_rx.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver, 16x oversampled, LSB first; optional parity via UART_RX_PARITY_EN
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int PAR_ODD = 0
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_rx,
  input  logic            i_s_tick,
  output logic            o_rx_done_tick,
  output logic [DBIT-1:0] o_dout,
  output logic            o_frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic            o_parity_err
`endif
);

  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  logic            rx_meta, rx_s;
  state_t          state_q, state_d;
  logic [4:0]      s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] sreg_q, sreg_d;
  logic            armed_q, armed_d;
  logic            done_d, ferr_d;
  logic [DBIT-1:0] dout_d;
`ifdef UART_RX_PARITY_EN
  logic            par_q, par_d;
  logic            perr_d;
`endif

  // Two-flop synchronizer on the asynchronous line; idles high out of reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
    end
  end

  // FSM state, counters and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q        <= IDLE;
      s_q            <= '0;
      n_q            <= '0;
      sreg_q         <= '0;
      armed_q        <= 1'b1;
      o_dout         <= '0;
      o_rx_done_tick <= 1'b0;
      o_frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q          <= 1'b0;
      o_parity_err   <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      s_q            <= s_d;
      n_q            <= n_d;
      sreg_q         <= sreg_d;
      armed_q        <= armed_d;
      o_dout         <= dout_d;
      o_rx_done_tick <= done_d;
      o_frame_err    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q          <= par_d;
      o_parity_err   <= perr_d;
`endif
    end
  end

  // Next-state logic: start detection is untimed, everything else steps on i_s_tick
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    sreg_d  = sreg_q;
    armed_d = armed_q;
    done_d  = 1'b0;
    dout_d  = o_dout;
    ferr_d  = o_frame_err;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = o_parity_err;
`endif
    case (state_q)
      IDLE: begin
        if (rx_s) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (i_s_tick) begin
          if (s_q == 5'd7) begin
            s_d = '0;
            if (!rx_s) begin
              state_d = DATA;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      DATA: begin
        if (i_s_tick) begin
          if (s_q == 5'd15) begin
            sreg_d = {rx_s, sreg_q[DBIT-1:1]};
            s_d    = '0;
            if (n_q == NW'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (i_s_tick) begin
          if (s_q == 5'd15) begin
            par_d   = rx_s;
            s_d     = '0;
            state_d = STOP;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
`endif
      STOP: begin
        if (i_s_tick) begin
          if (s_q == 5'(SB_TICK - 1)) begin
            state_d = IDLE;
            s_d     = '0;
            done_d  = 1'b1;
            dout_d  = sreg_q;
            ferr_d  = ~rx_s;
            // A low stop bit means a break may follow; wait for the line to rise before re-arming
            if (!rx_s) armed_d = 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_d  = ((^sreg_q) ^ par_q) != 1'(PAR_ODD);
`endif
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard testbench for uart_rx
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       i_reset;
  logic       i_rx;
  logic       i_s_tick;
  logic       o_rx_done_tick;
  logic [7:0] o_dout;
  logic       o_frame_err;
`ifdef UART_RX_PARITY_EN
  logic       o_parity_err;
  localparam int LAT_EXTRA = 64;
`else
  localparam int LAT_EXTRA = 0;
`endif

  uart_rx #(.DBIT(8), .SB_TICK(16), .PAR_ODD(0)) dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_rx           (i_rx),
    .i_s_tick       (i_s_tick),
    .o_rx_done_tick (o_rx_done_tick),
    .o_dout         (o_dout),
    .o_frame_err    (o_frame_err)
`ifdef UART_RX_PARITY_EN
    ,
    .o_parity_err   (o_parity_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         start_cyc = 0;
  int         done_cyc = -1;
  int         ndone = 0;
  logic       skip = 1'b1;
  logic [7:0] last_dout = 8'h00;
  logic       last_fe = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // 16x tick: one clock high every 4 clocks
  initial begin
    i_s_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      i_s_tick = 1'b1;
      @(negedge clk);
      i_s_tick = 1'b0;
    end
  end

  // Monitor: pops the scoreboard on each done pulse and watches output stability otherwise
  always @(negedge clk) begin
    if (o_rx_done_tick) begin
      ndone    = ndone + 1;
      done_cyc = cyc;
      checks   = checks + 1;
      if (sb.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_done dout=%h (no frame expected)", o_dout);
      end else begin
        e = sb.pop_front();
        if (o_dout !== e.d) begin
          errors = errors + 1;
          $display("FAIL dout got=%h exp=%h", o_dout, e.d);
        end
        checks = checks + 1;
        if (o_frame_err !== e.fe) begin
          errors = errors + 1;
          $display("FAIL frame_err got=%b exp=%b data=%h", o_frame_err, e.fe, e.d);
        end
`ifdef UART_RX_PARITY_EN
        checks = checks + 1;
        if (o_parity_err !== e.pe) begin
          errors = errors + 1;
          $display("FAIL parity_err got=%b exp=%b data=%h", o_parity_err, e.pe, e.d);
        end
`endif
      end
      last_dout = o_dout;
      last_fe   = o_frame_err;
    end else if (!skip) begin
      checks = checks + 1;
      if (o_dout !== last_dout || o_frame_err !== last_fe) begin
        errors = errors + 1;
        $display("FAIL hold got=%h/%b exp=%h/%b", o_dout, o_frame_err, last_dout, last_fe);
      end
    end else begin
      last_dout = o_dout;
      last_fe   = o_frame_err;
    end
  end

  task automatic send_bit(input logic b);
    i_rx = b;
    repeat (64) @(negedge clk);
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic fe, input logic pe);
    exp_t t;
    t.d  = d;
    t.fe = fe;
    t.pe = pe;
    sb.push_back(t);
  endtask

  // Start bit, 8 data bits LSB first, parity bit when compiled in, stop bit
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    @(negedge clk);
    i_rx = 1'b0;
    start_cyc = cyc;
    repeat (64) @(negedge clk);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
`else
    if (par) begin end
`endif
    send_bit(stop);
  endtask

  task automatic idle(input int bits);
    i_rx = 1'b1;
    repeat (bits * 64) @(negedge clk);
  endtask

  task automatic check_val(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic check_window(input string name, input int got, input int lo, input int hi);
    checks = checks + 1;
    if (got < lo || got > hi) begin
      errors = errors + 1;
      $display("FAIL %s got=%0d exp=%0d..%0d", name, got, lo, hi);
    end
  endtask

  initial begin
    int n0;
    i_reset = 1'b1;
    i_rx    = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_val("reset_dout", o_dout, 8'h00);
    check_val("reset_done", {7'd0, o_rx_done_tick}, 8'h00);
    check_val("reset_ferr", {7'd0, o_frame_err}, 8'h00);
`ifdef UART_RX_PARITY_EN
    check_val("reset_perr", {7'd0, o_parity_err}, 8'h00);
`endif
    @(negedge clk);
    i_reset = 1'b0;
    @(negedge clk);
    skip = 1'b0;
    idle(2);

    // 1: single frame 0xA5, latency about 9.5 bits plus sync delay
    expect_frame(8'hA5, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b0, 1'b1);
    check_window("latency_a5", done_cyc - start_cyc, 606 + LAT_EXTRA, 613 + LAT_EXTRA);
    idle(2);

    // 2: back-to-back frames, no idle gap
    n0 = ndone;
    expect_frame(8'h00, 1'b0, 1'b0);
    send_frame(8'h00, 1'b0, 1'b1);
    expect_frame(8'hFF, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b1);
    expect_frame(8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b1);
    idle(2);
    check_val("b2b_count", 8'(ndone - n0), 8'd3);

    // 3: 16-clock low glitch must be rejected, then 0x5A received
    n0 = ndone;
    @(negedge clk);
    i_rx = 1'b0;
    repeat (16) @(negedge clk);
    idle(2);
    check_val("glitch_count", 8'(ndone - n0), 8'd0);
    expect_frame(8'h5A, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b1);
    idle(2);

    // 4: 0x81 with a low stop bit, line held low (break), then a clean frame
    n0 = ndone;
    expect_frame(8'h81, 1'b1, 1'b0);
    send_frame(8'h81, 1'b0, 1'b0);
    i_rx = 1'b0;
    repeat (3 * 64) @(negedge clk);
    check_val("break_count", 8'(ndone - n0), 8'd1);
    idle(2);
    check_val("break_release_count", 8'(ndone - n0), 8'd1);
    expect_frame(8'h55, 1'b0, 1'b0);
    send_frame(8'h55, 1'b0, 1'b1);
    idle(2);

    // 5: reset in the middle of data bit 4 of 0xC3
    n0 = ndone;
    @(negedge clk);
    i_rx = 1'b0;
    repeat (64) @(negedge clk);
    for (int i = 0; i < 4; i++) send_bit(1'(8'hC3 >> i));
    i_rx = 1'b0;
    repeat (32) @(negedge clk);
    skip = 1'b1;
    i_reset = 1'b1;
    i_rx = 1'b1;
    @(posedge clk);
    #1;
    check_val("midreset_dout", o_dout, 8'h00);
    check_val("midreset_done", {7'd0, o_rx_done_tick}, 8'h00);
    check_val("midreset_ferr", {7'd0, o_frame_err}, 8'h00);
    @(negedge clk);
    i_reset = 1'b0;
    @(negedge clk);
    skip = 1'b0;
    idle(2);
    check_val("midreset_count", 8'(ndone - n0), 8'd0);
    expect_frame(8'h96, 1'b0, 1'b0);
    send_frame(8'h96, 1'b0, 1'b1);
    idle(2);

`ifdef UART_RX_PARITY_EN
    // 6: even parity on 0x07 (three ones)
    expect_frame(8'h07, 1'b0, 1'b0);
    send_frame(8'h07, 1'b1, 1'b1);
    idle(1);
    expect_frame(8'h07, 1'b0, 1'b1);
    send_frame(8'h07, 1'b0, 1'b1);
    idle(2);
`endif

    check_val("sb_empty", 8'(sb.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule
